// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master.
//   state_t       : transfer sequencer states (3-bit encoding, IDLE..GAP)
//   SPI_WIDTH_DEF : default bits per transfer
//   CLK_DIV_DEF   : default clk cycles per SCK half-period
package spi_master_pkg;

  localparam int SPI_WIDTH_DEF = 8;
  localparam int CLK_DIV_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_master_if.sv
// Host handshake and SPI pin bundle for spi_master.
//   start, master_din          : host request and word to send
//   busy, done, master_dout    : host status and received word
//   cs, sck, mosi              : SPI pins driven by the master
//   miso                       : SPI pin driven by the slave
// Modports: master (the spi_master view), slave (host/slave-side view).
interface spi_master_if
  import spi_master_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] master_din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] master_dout;
  logic             cs;
  logic             sck;
  logic             mosi;
  logic             miso;

  modport master (
    input  start, master_din, miso,
    output busy, done, master_dout, cs, sck, mosi
  );

  modport slave (
    output start, master_din, miso,
    input  busy, done, master_dout, cs, sck, mosi
  );

endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0), MSB first, one WIDTH-bit full-duplex word per
// request. SCK is clk divided by 2*CLK_DIV; every non-IDLE state lasts
// exactly CLK_DIV clk cycles. All outputs are registered.
// Ports:
//   clk    : system clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : spi_master_if.master (start/master_din/busy/done/master_dout,
//            cs/sck/mosi/miso)
module spi_master
  import spi_master_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_master_if.master  bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             phase_end;
  logic             take;

  assign phase_end = (div_cnt == DIV_LAST);

  // The GAP exit edge is the edge on which IDLE is reached, so a start held
  // high there launches the next word immediately: cs stays high for exactly
  // one GAP between back-to-back words.
  assign take = bus.start && ((state == ST_IDLE) || (state == ST_GAP && phase_end));

  // NOTE: every register here is assigned with <= so all of them update
  // together from the pre-edge values; a blocking = would let later lines see
  // half-updated state and break the shift registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      bus.cs          <= 1'b1;
      bus.sck         <= 1'b0;
      bus.mosi        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.master_dout <= '0;
    end else begin
      bus.done <= 1'b0;
      if (take) begin
        state    <= ST_SETUP;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        tx_sr    <= bus.master_din;
        bus.mosi <= bus.master_din[WIDTH-1];
        bus.cs   <= 1'b0;
        bus.busy <= 1'b1;
      end else if (state != ST_IDLE) begin
        if (!phase_end) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          case (state)
            ST_SETUP: begin
              bus.sck <= 1'b1;
              state   <= ST_HIGH;
            end
            ST_HIGH: begin
              // Falling SCK edge is the sample point; the slave updated miso
              // on the previous falling edge, a full SCK period ago.
              bus.sck <= 1'b0;
              rx_sr   <= {rx_sr[WIDTH-2:0], bus.miso};
              bit_cnt <= bit_cnt + 1'b1;
              state   <= ST_LOW;
            end
            ST_LOW: begin
              if (bit_cnt == BIT_LAST) begin
                state <= ST_HOLD;
              end else begin
                // mosi moves with the rising SCK edge so it is stable for the
                // whole bit cell as seen by the slave's delayed edge detect.
                bus.sck  <= 1'b1;
                tx_sr    <= tx_sr << 1;
                bus.mosi <= tx_sr[WIDTH-2];
                state    <= ST_HIGH;
              end
            end
            ST_HOLD: begin
              bus.cs          <= 1'b1;
              bus.done        <= 1'b1;
              bus.master_dout <= rx_sr;
              bus.mosi        <= 1'b0;
              state           <= ST_GAP;
            end
            ST_GAP: begin
              bus.busy <= 1'b0;
              state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master. A behavioural mode-0 slave answers on
// miso and captures mosi; a scoreboard holds the word each transfer must
// return to the host and the word the slave must capture.
module tb_spi_master;

  localparam int WIDTH   = 8;
  localparam int CLK_DIV = 4;
  localparam int CS_LOW  = CLK_DIV * (2 * WIDTH + 2);  // 72
  localparam int DONE_K  = CS_LOW;                      // done after accept edge + 72
  localparam int BUSY_K  = CS_LOW + CLK_DIV;            // busy low after accept edge + 76

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if #(.WIDTH(WIDTH)) bus ();

  spi_master #(.WIDTH(WIDTH), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q_dout[$];  // expected master_dout per transfer
  logic [WIDTH-1:0] q_mosi[$];  // expected word captured by slave

  // Slave model
  logic [WIDTH-1:0] slv_tx = '0;
  logic [WIDTH-1:0] slv_sh = '0;
  logic [WIDTH-1:0] slv_rx = '0;
  int               slv_bits = 0;
  bit               tie_en = 1'b0;
  logic             cs_prev = 1'b1;
  logic             sck_prev = 1'b0;

  always @(negedge clk) begin
    if (cs_prev === 1'b1 && bus.cs === 1'b0) begin
      slv_sh   = slv_tx;
      slv_rx   = '0;
      slv_bits = 0;
      if (!tie_en) bus.miso = slv_tx[WIDTH-1];
    end else if (bus.cs === 1'b0) begin
      if (sck_prev === 1'b0 && bus.sck === 1'b1) begin
        slv_rx   = {slv_rx[WIDTH-2:0], bus.mosi};
        slv_bits = slv_bits + 1;
      end
      if (sck_prev === 1'b1 && bus.sck === 1'b0) begin
        slv_sh = slv_sh << 1;
        if (!tie_en) bus.miso = slv_sh[WIDTH-1];
      end
    end
    if (cs_prev === 1'b0 && bus.cs === 1'b1 && slv_bits == WIDTH) begin
      checks++;
      if (q_mosi.size() == 0) begin
        errors++;
        $display("FAIL slave_word: got %h with no transfer expected", slv_rx);
      end else begin
        logic [WIDTH-1:0] exp_m;
        exp_m = q_mosi.pop_front();
        if (slv_rx !== exp_m) begin
          errors++;
          $display("FAIL slave_word: got %h expected %h", slv_rx, exp_m);
        end
      end
    end
    cs_prev  = bus.cs;
    sck_prev = bus.sck;
  end

  // Host-side scoreboard: every done pulse pops one expected word.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (q_dout.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: master_dout=%h", bus.master_dout);
      end else begin
        logic [WIDTH-1:0] exp_d;
        exp_d = q_dout.pop_front();
        if (bus.master_dout !== exp_d) begin
          errors++;
          $display("FAIL master_dout: got %h expected %h", bus.master_dout, exp_d);
        end
      end
    end
  end

  // Bounded wait for busy to drop.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, bus.busy, n);
    end
  endtask

  // Launch one transfer and observe n samples, k=0 being just after the
  // accept edge. Start is re-pulsed before edges poke_a and poke_b.
  task automatic run_xfer(input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] sw,
                          input bit push, input int n, input int poke_a, input int poke_b,
                          output int done_k, output int ndone, output int cs_low,
                          output int busy_k, output int pulses, output int bad_len,
                          output int bad_mosi, output int cs_falls);
    logic p_sck, p_mosi, p_cs;
    int   hi_len, low_len;
    bit   rose, fell;
    @(negedge clk);
    slv_tx = sw;
    bus.master_din = din;
    bus.start = 1'b1;
    if (push) begin
      q_dout.push_back(sw);
      q_mosi.push_back(din);
    end
    p_sck = bus.sck; p_mosi = bus.mosi; p_cs = bus.cs;
    done_k = -1; ndone = 0; cs_low = 0; busy_k = -1; pulses = 0;
    bad_len = 0; bad_mosi = 0; cs_falls = 0; hi_len = 0; low_len = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.master_din = ~din;  // must not disturb the word in flight
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (bus.cs === 1'b0) cs_low++;
      if (p_cs === 1'b1 && bus.cs === 1'b0) cs_falls++;
      if (bus.busy === 1'b0 && busy_k < 0) busy_k = k;
      rose = (p_sck === 1'b0 && bus.sck === 1'b1);
      fell = (p_sck === 1'b1 && bus.sck === 1'b0);
      if (rose) begin
        pulses++;
        if (pulses > 1 && low_len != CLK_DIV) bad_len++;
        hi_len = 0;
      end
      if (fell) begin
        if (hi_len != CLK_DIV) bad_len++;
        low_len = 0;
      end
      if (bus.sck === 1'b1) hi_len++; else low_len++;
      if (bus.mosi !== p_mosi && !rose && k != 0 && !(p_cs === 1'b0 && bus.cs === 1'b1))
        bad_mosi++;
      p_sck = bus.sck; p_mosi = bus.mosi; p_cs = bus.cs;
      bus.start = (k == poke_a - 1 || k == poke_b - 1);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;  // reset must win over start
    bus.master_din = 8'hFF;
    bus.miso = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (bus.cs !== 1'b1)    begin errors++; $display("FAIL reset_cs: got %b expected 1", bus.cs); end
    if (bus.sck !== 1'b0)   begin errors++; $display("FAIL reset_sck: got %b expected 0", bus.sck); end
    if (bus.mosi !== 1'b0)  begin errors++; $display("FAIL reset_mosi: got %b expected 0", bus.mosi); end
    if (bus.busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.master_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.master_dout); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Shared timing checks for a single, undisturbed transfer.
  task automatic check_timing(input string name, input int done_k, input int ndone,
                              input int cs_low, input int busy_k);
    checks += 4;
    if (done_k != DONE_K) begin errors++; $display("FAIL %s_done_edge: got %0d expected %0d", name, done_k, DONE_K); end
    if (ndone != 1)       begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, ndone); end
    if (cs_low != CS_LOW) begin errors++; $display("FAIL %s_cs_low: got %0d expected %0d", name, cs_low, CS_LOW); end
    if (busy_k != BUSY_K) begin errors++; $display("FAIL %s_busy_fall: got %0d expected %0d", name, busy_k, BUSY_K); end
  endtask

  task automatic test_loopback();
    int dk, nd, cl, bk, pu, bl, bm, cf;
    run_xfer(8'hA5, 8'h3C, 1'b1, 80, -1, -1, dk, nd, cl, bk, pu, bl, bm, cf);
    check_timing("loopback", dk, nd, cl, bk);
    wait_idle("loopback");
  endtask

  task automatic test_waveform();
    int dk, nd, cl, bk, pu, bl, bm, cf;
    run_xfer(8'h96, 8'h69, 1'b1, 80, -1, -1, dk, nd, cl, bk, pu, bl, bm, cf);
    checks += 3;
    if (pu != WIDTH) begin errors++; $display("FAIL wave_pulses: got %0d expected %0d", pu, WIDTH); end
    if (bl != 0)     begin errors++; $display("FAIL wave_sck_len: got %0d bad half-periods expected 0", bl); end
    if (bm != 0)     begin errors++; $display("FAIL wave_mosi_edge: got %0d off-edge changes expected 0", bm); end
    wait_idle("waveform");
  endtask

  task automatic test_miso_tied();
    int dk, nd, cl, bk, pu, bl, bm, cf;
    tie_en = 1'b1;
    bus.miso = 1'b1;
    run_xfer(8'h55, 8'hFF, 1'b1, 80, -1, -1, dk, nd, cl, bk, pu, bl, bm, cf);
    check_timing("miso1", dk, nd, cl, bk);
    wait_idle("miso1");
    bus.miso = 1'b0;
    run_xfer(8'hAA, 8'h00, 1'b1, 80, -1, -1, dk, nd, cl, bk, pu, bl, bm, cf);
    check_timing("miso0", dk, nd, cl, bk);
    wait_idle("miso0");
    tie_en = 1'b0;
  endtask

  task automatic test_start_ignored();
    int dk, nd, cl, bk, pu, bl, bm, cf;
    run_xfer(8'hE7, 8'h18, 1'b1, 160, 10, 40, dk, nd, cl, bk, pu, bl, bm, cf);
    checks += 3;
    if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    if (cf != 1) begin errors++; $display("FAIL ignore_cs_falls: got %0d expected 1", cf); end
    if (bk != BUSY_K) begin errors++; $display("FAIL ignore_busy_fall: got %0d expected %0d", bk, BUSY_K); end
  endtask

  task automatic test_back_to_back();
    int gap, second_k;
    bit second;
    @(negedge clk);
    slv_tx = 8'hC1;
    bus.master_din = 8'h01;
    bus.start = 1'b1;
    q_dout.push_back(8'hC1);
    q_mosi.push_back(8'h01);
    gap = 0; second = 1'b0; second_k = -1;
    for (int k = 0; k < 200 && !second; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.master_din = 8'h80;
        slv_tx = 8'h7E;
        q_dout.push_back(8'h7E);
        q_mosi.push_back(8'h80);
      end
      if (k >= CS_LOW) begin
        if (bus.cs === 1'b1) gap++;
        else begin
          second = 1'b1;
          second_k = k;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks += 2;
    if (gap != CLK_DIV) begin errors++; $display("FAIL b2b_cs_gap: got %0d expected %0d", gap, CLK_DIV); end
    if (second_k != BUSY_K) begin errors++; $display("FAIL b2b_second_accept: got %0d expected %0d", second_k, BUSY_K); end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid();
    int nd;
    int dk, ndn, cl, bk, pu, bl, bm, cf;
    @(negedge clk);
    slv_tx = 8'h99;
    bus.master_din = 8'hC3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bus.cs !== 1'b1)   begin errors++; $display("FAIL midrst_cs: got %b expected 1", bus.cs); end
    if (bus.sck !== 1'b0)  begin errors++; $display("FAIL midrst_sck: got %b expected 0", bus.sck); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    if (bus.master_dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h expected 00", bus.master_dout); end
    rst_n = 1'b1;
    nd = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", nd); end
    run_xfer(8'h5A, 8'hA3, 1'b1, 80, -1, -1, dk, ndn, cl, bk, pu, bl, bm, cf);
    check_timing("after_rst", dk, ndn, cl, bk);
    wait_idle("after_rst");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.master_din = '0;
    bus.miso = 1'b0;
    test_reset();
    test_loopback();
    test_waveform();
    test_miso_tied();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks += 2;
    if (q_dout.size() != 0) begin errors++; $display("FAIL pending_dout: got %0d left expected 0", q_dout.size()); end
    if (q_mosi.size() != 0) begin errors++; $display("FAIL pending_slave: got %0d left expected 0", q_mosi.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
